booth_multiplier: RTL and testbench
===================================

// Module: booth_multiplier
// PURPOSE
// Sequential signed multiplier using radix-2 Booth recoding; the counterpart to
// the non-restoring divider in the arithmetic unit. It accepts two WIDTH-bit
// two's-complement operands on a start strobe and produces a 2*WIDTH-bit
// signed product after a fixed number of cycles. It uses the same start/ready
// handshake as the divider, so both units share one controller.
// PARAMETERS
// WIDTH     8   operand width in bits (>=2); product is 2*WIDTH bits
// CNT_W     4   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// clk           in   1         rising-edge clock
// reset         in   1         asynchronous, active-high reset
// start         in   1         request; sampled only when not busy
// multiplicand  in   WIDTH     signed operand M, captured on accepted start
// multiplier    in   WIDTH     signed operand Q, captured on accepted start
// product       out  2*WIDTH   signed result M*Q, registered
// busy          out  1         high from accepted start until result written
// ready         out  1         result valid; held until next accepted start
// BEHAVIOUR
// - Reset (async, any state, including mid-computation): state=IDLE, all
//   internal registers 0, product=0, busy=0, ready=0. A new start on the first
//   edge after reset deasserts is accepted normally.
// - States: IDLE -> COMPUTE -> DONE -> IDLE.
// - IDLE: on start=1, load A=0 (WIDTH+1 bits), Q=multiplier, q_m1=0,
//   M=sign-extended multiplicand (WIDTH+1 bits), counter=WIDTH. Set busy=1 and
//   ready=0, then go to COMPUTE. product keeps its old value until DONE.
// - COMPUTE, once per cycle: the Booth pair is {Q[0],q_m1}. 01: A=A+M;
//   10: A=A-M; 00/11: A is unchanged. The sum is WIDTH+1 bits wide, so it
//   cannot overflow, including for M=-2**(WIDTH-1). Then arithmetic-shift
//   {A,Q,q_m1} right by 1, replicating A's MSB. Decrement the counter. When the
//   counter is 1 this cycle, go to DONE.
// - DONE (1 cycle): product <= {A[WIDTH-1:0],Q}, ready <= 1, busy <= 0, then
//   go to IDLE.
// - Latency is fixed and independent of operand values. With the start edge as
//   edge 0, product and ready are valid after edge WIDTH+1. A new start can be
//   accepted on edge WIDTH+2.
// - start while busy=1 is ignored. The operands are not re-sampled and the
//   running computation is unaffected.
// - start held high continuously gives back-to-back operations, one every
//   WIDTH+2 cycles. ready pulses high for one cycle between them, because it is
//   cleared on the accepted start.
// - Operand inputs are don't-care except on the accepted-start edge.
// - Illegal state encoding goes to IDLE on the next edge.
// - There is no overflow flag. Every WIDTH-bit signed product fits in
//   2*WIDTH bits.
// TESTING
// 1. Reset, then start with M=7, Q=6 -> after WIDTH+1=9 edges product=16'h002A,
//    ready=1, busy=0.
// 2. M=-128, Q=-128 -> product=16'h4000. M=127, Q=-128 -> product=16'hC080.
//    M=-1, Q=1 -> product=16'hFFFF.
// 3. M=0, Q=8'h5A, then M=8'h5A, Q=0 -> product=16'h0000. Latency is still 9
//    edges.
// 4. Start M=3, Q=5; on edge 3 assert start with M=9, Q=9 -> product=16'h000F
//    (second request ignored), busy stays high throughout.
// 5. Start M=100, Q=100; assert reset on edge 4 -> product=0, ready=0, busy=0
//    at once. Next start with M=2, Q=-3 -> product=16'hFFFA.
// 6. Hold start=1 for two operations (M=5,Q=5 then M=-5,Q=5) -> 16'h0019 then
//    16'hFFE7, results spaced 10 cycles apart. Also run a random signed sweep
//    against a reference model.

Source files
------------

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth signed multiplier with a start/busy/ready handshake.
// Produces a 2*WIDTH-bit product WIDTH+1 clock edges after an accepted start.
module booth_multiplier #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic                 ready
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

   state_t             state_r;
   state_t             state_s;
   logic [WIDTH:0]     a_r;
   logic [WIDTH:0]     m_r;
   logic [WIDTH:0]     sum_s;
   logic [WIDTH-1:0]   q_r;
   logic               qm1_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [2*WIDTH-1:0] product_r;
   logic               busy_r;
   logic               ready_r;

   assign product = product_r;
   assign busy    = busy_r;
   assign ready   = ready_r;

   // Booth add/subtract step; A is one bit wider than the operand so it never overflows
   always_comb begin
      sum_s = a_r;
      case ({q_r[0], qm1_r})
         2'b01:   sum_s = a_r + m_r;
         2'b10:   sum_s = a_r - m_r;
         default: sum_s = a_r;
      endcase
   end

   // Next-state logic; unused encodings fall back to IDLE
   always_comb begin
      state_s = IDLE;
      case (state_r)
         IDLE: begin
            if (start) state_s = COMPUTE;
            else       state_s = IDLE;
         end
         COMPUTE: begin
            if (cnt_r == CNT_ONE) state_s = DONE;
            else                  state_s = COMPUTE;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_s;
   end

   // Datapath and handshake registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_r       <= '0;
         m_r       <= '0;
         q_r       <= '0;
         qm1_r     <= 1'b0;
         cnt_r     <= '0;
         product_r <= '0;
         busy_r    <= 1'b0;
         ready_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_r     <= '0;
                  m_r     <= {multiplicand[WIDTH-1], multiplicand};
                  q_r     <= multiplier;
                  qm1_r   <= 1'b0;
                  cnt_r   <= CNT_LOAD;
                  busy_r  <= 1'b1;
                  ready_r <= 1'b0;
               end
            end
            COMPUTE: begin
               // arithmetic shift of {A,Q,q_m1}, replicating A's sign bit
               {a_r, q_r, qm1_r} <= {sum_s[WIDTH], sum_s, q_r};
               cnt_r             <= cnt_r - CNT_ONE;
            end
            DONE: begin
               product_r <= {a_r[WIDTH-1:0], q_r};
               ready_r   <= 1'b1;
               busy_r    <= 1'b0;
            end
            default: begin
               busy_r  <= 1'b0;
               ready_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed cases plus a random signed
// sweep compared against an integer-arithmetic reference.
module tb_booth_multiplier;

   localparam int WIDTH = 8;
   localparam int LAT   = WIDTH + 1;

   logic                 clk;
   logic                 reset;
   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;
   logic                 ready;

   int n_tests;
   int n_fail;

   booth_multiplier #(.WIDTH(WIDTH), .CNT_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .busy         (busy),
      .ready        (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
      logic signed [WIDTH-1:0] ms;
      logic signed [WIDTH-1:0] qs;
      int mi;
      int qi;
      int p;
      ms = m;
      qs = q;
      mi = ms;
      qi = qs;
      p  = mi * qi;
      return p[2*WIDTH-1:0];
   endfunction

   // one full operation: start pulse, count edges to ready, check product
   task automatic do_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q,
                        input logic [2*WIDTH-1:0] exp, input string tag);
      int edges;
      @(negedge clk);
      start        = 1'b1;
      multiplicand = m;
      multiplier   = q;
      @(posedge clk);
      @(negedge clk);
      start        = 1'b0;
      multiplicand = WIDTH'($urandom);
      multiplier   = WIDTH'($urandom);
      check_val({tag, " busy_after_start"}, 32'(busy), 32'd1);
      edges = 0;
      while (!ready && edges < 50) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check_val({tag, " latency"}, 32'(edges), 32'(LAT));
      check_val({tag, " product"}, 32'(product), 32'(exp));
      check_val({tag, " busy_done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int edges;
      int first_e;
      int second_e;
      int ready_hi;
      logic [2*WIDTH-1:0] p1;
      logic [2*WIDTH-1:0] p2;
      logic [WIDTH-1:0] rm;
      logic [WIDTH-1:0] rq;
      n_tests      = 0;
      n_fail       = 0;
      reset        = 1'b1;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("reset product", 32'(product), 32'd0);
      check_val("reset ready", 32'(ready), 32'd0);
      check_val("reset busy", 32'(busy), 32'd0);
      reset = 1'b0;

      do_op(8'd7, 8'd6, 16'h002A, "t1 7x6");
      do_op(8'h80, 8'h80, 16'h4000, "t2 -128x-128");
      do_op(8'd127, 8'h80, 16'hC080, "t2 127x-128");
      do_op(8'hFF, 8'd1, 16'hFFFF, "t2 -1x1");
      do_op(8'd0, 8'h5A, 16'h0000, "t3 0x5A");
      do_op(8'h5A, 8'd0, 16'h0000, "t3 5Ax0");

      // ready and product hold while idle
      repeat (3) @(negedge clk);
      check_val("t3 ready_hold", 32'(ready), 32'd1);
      check_val("t3 product_hold", 32'(product), 32'd0);

      // t4: second start during computation is ignored
      @(negedge clk);
      start = 1'b1; multiplicand = 8'd3; multiplier = 8'd5;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_val("t4 ready_cleared", 32'(ready), 32'd0);
      edges = 0;
      while (!ready && edges < 50) begin
         if (edges == 2) begin
            start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (!ready) check_val("t4 busy_high", 32'(busy), 32'd1);
      end
      start = 1'b0;
      check_val("t4 latency", 32'(edges), 32'(LAT));
      check_val("t4 product", 32'(product), 32'h000F);
      repeat (3) @(negedge clk);
      check_val("t4 no_restart", 32'(busy), 32'd0);

      // t5: asynchronous reset mid-computation
      @(negedge clk);
      start = 1'b1; multiplicand = 8'd100; multiplier = 8'd100;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_val("t5 rst product", 32'(product), 32'd0);
      check_val("t5 rst ready", 32'(ready), 32'd0);
      check_val("t5 rst busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      do_op(8'd2, 8'hFD, 16'hFFFA, "t5 2x-3");

      // t6: start held high gives back-to-back operations
      @(negedge clk);
      start = 1'b1; multiplicand = 8'd5; multiplier = 8'd5;
      @(posedge clk);
      @(negedge clk);
      multiplicand = 8'hFB; multiplier = 8'd5;
      edges = 0; first_e = -1; second_e = -1; ready_hi = 0;
      p1 = '0; p2 = '0;
      while (second_e < 0 && edges < 60) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (ready) begin
            if (first_e < 0) begin
               first_e = edges; p1 = product;
            end else if (!ready_prev_hi(ready_hi, first_e, edges)) begin
               second_e = edges; p2 = product; start = 1'b0;
            end
            if (first_e >= 0 && second_e < 0) ready_hi++;
         end
      end
      start = 1'b0;
      check_val("t6 first_edge", 32'(first_e), 32'(LAT));
      check_val("t6 first_product", 32'(p1), 32'h0019);
      check_val("t6 ready_pulse_len", 32'(ready_hi), 32'd1);
      check_val("t6 spacing", 32'(second_e - first_e), 32'(WIDTH + 2));
      check_val("t6 second_product", 32'(p2), 32'hFFE7);
      repeat (2) @(negedge clk);
      check_val("t6 stopped", 32'(busy), 32'd0);

      // random signed sweep
      for (int i = 0; i < 24; i++) begin
         rm = WIDTH'($urandom);
         rq = WIDTH'($urandom);
         do_op(rm, rq, ref_mul(rm, rq), $sformatf("rand%0d %0h*%0h", i, rm, rq));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ready seen on the edge right after the first result belongs to the same pulse
   function automatic bit ready_prev_hi(input int hi_cnt, input int first_edge, input int now_edge);
      return (now_edge - first_edge) < hi_cnt;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
